// File: rtl/pack_send.sv
`timescale 1ns/1ps
// pack_send: fetches one 8-word frame from the packet buffer into a local
// store, then streams it as SYNC + 16 data bytes + XOR checksum to the link
// layer, retransmitting from the local store on NAK or ACK timeout.
module pack_send #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         ACK_TIMEOUT = 1024,
   parameter int         MAX_RETRIES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] DataVal,
   input  logic        DataReady,
   output logic        DataNext,
   output logic        DataFrameReset,
   input  logic        Abort,
   output logic [7:0]  TxByte,
   output logic        TxValid,
   input  logic        TxReady,
   input  logic        LinkAck,
   input  logic        LinkNak,
   output logic        FrameSent,
   output logic        FrameDropped,
   output logic        Busy
);

   localparam int            RW      = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [15:0]   TO_LAST = 16'(ACK_TIMEOUT - 1);
   localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_NEXT_HI, S_SETTLE, S_ADV_WAIT, S_SEND, S_WAIT_ACK
   } state_t;

   state_t        r_state, w_state;
   logic [2:0]    r_wcnt, w_wcnt;
   logic [4:0]    r_bcnt, w_bcnt;
   logic [15:0]   r_tcnt, w_tcnt;
   logic [RW-1:0] r_rcnt, w_rcnt;
   logic          r_settle, w_settle;
   logic          r_next, w_next;
   logic          r_frst, w_frst;
   logic          r_txv, w_txv;
   logic [7:0]    r_txb, w_txb;
   logic          r_sent, w_sent;
   logic          r_drop, w_drop;

   // Local frame store and running checksum (data path, no reset needed).
   logic [15:0]   r_word [8];
   logic [7:0]    r_chk;

   logic [15:0]   w_wsel;
   logic [7:0]    w_nbyte;
   logic          w_timeout;

   // Byte that follows the one currently presented: bcnt 0..15 walk the
   // store low byte first, bcnt 16 is followed by the checksum.
   assign w_wsel    = r_word[r_bcnt[3:1]];
   assign w_nbyte   = (r_bcnt == 5'd16) ? r_chk : (r_bcnt[0] ? w_wsel[15:8] : w_wsel[7:0]);
   assign w_timeout = (r_tcnt == TO_LAST);

   assign DataNext       = r_next;
   assign DataFrameReset = r_frst;
   assign TxByte         = r_txb;
   assign TxValid        = r_txv;
   assign FrameSent      = r_sent;
   assign FrameDropped   = r_drop;
   assign Busy           = (r_state != S_IDLE);

   // Capture the current buffer word and fold it into the checksum.
   always_ff @(posedge clk) begin
      if (r_state == S_CAPTURE) begin
         r_word[r_wcnt] <= DataVal;
         r_chk          <= r_chk ^ DataVal[7:0] ^ DataVal[15:8];
      end else if (r_state == S_IDLE) begin
         r_chk <= 8'h00;
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      w_state  = r_state;
      w_wcnt   = r_wcnt;
      w_bcnt   = r_bcnt;
      w_tcnt   = r_tcnt;
      w_rcnt   = r_rcnt;
      w_settle = r_settle;
      w_next   = 1'b0;
      w_frst   = 1'b0;
      w_txv    = r_txv;
      w_txb    = r_txb;
      w_sent   = 1'b0;
      w_drop   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (DataReady) begin
               w_wcnt  = 3'd0;
               w_state = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (Abort) begin
               w_frst  = 1'b1;
               w_state = S_IDLE;
            end else begin
               w_state = S_ADV_WAIT;
            end
         end
         S_ADV_WAIT: begin
            if (Abort) begin
               w_frst  = 1'b1;
               w_state = S_IDLE;
            end else if (DataReady) begin
               w_next  = 1'b1;
               w_state = S_NEXT_HI;
            end
         end
         S_NEXT_HI: begin
            if (Abort) begin
               w_frst  = 1'b1;
               w_state = S_IDLE;
            end else begin
               w_settle = 1'b0;
               w_state  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (Abort) begin
               w_frst  = 1'b1;
               w_state = S_IDLE;
            end else if (!r_settle) begin
               w_settle = 1'b1;
            end else if (r_wcnt == 3'd7) begin
               w_bcnt  = 5'd0;
               w_txv   = 1'b1;
               w_txb   = SYNC_BYTE;
               w_state = S_SEND;
            end else begin
               w_wcnt  = r_wcnt + 3'd1;
               w_state = S_CAPTURE;
            end
         end
         S_SEND: begin
            if (Abort) begin
               w_txv   = 1'b0;
               w_drop  = 1'b1;
               w_rcnt  = '0;
               w_state = S_IDLE;
            end else if (TxReady) begin
               if (r_bcnt == 5'd17) begin
                  w_txv   = 1'b0;
                  w_tcnt  = 16'd0;
                  w_state = S_WAIT_ACK;
               end else begin
                  w_bcnt = r_bcnt + 5'd1;
                  w_txb  = w_nbyte;
               end
            end
         end
         S_WAIT_ACK: begin
            w_tcnt = r_tcnt + 16'd1;
            if (Abort) begin
               w_drop  = 1'b1;
               w_rcnt  = '0;
               w_state = S_IDLE;
            end else if (LinkNak || (!LinkAck && w_timeout)) begin
               if (r_rcnt < RMAX) begin
                  // Retransmit from the local store; the buffer is not touched.
                  w_rcnt  = r_rcnt + RW'(1);
                  w_bcnt  = 5'd0;
                  w_txv   = 1'b1;
                  w_txb   = SYNC_BYTE;
                  w_state = S_SEND;
               end else begin
                  w_drop  = 1'b1;
                  w_rcnt  = '0;
                  w_state = S_IDLE;
               end
            end else if (LinkAck) begin
               w_sent  = 1'b1;
               w_rcnt  = '0;
               w_state = S_IDLE;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // Control state and outputs, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_wcnt   <= 3'd0;
         r_bcnt   <= 5'd0;
         r_tcnt   <= 16'd0;
         r_rcnt   <= '0;
         r_settle <= 1'b0;
         r_next   <= 1'b0;
         r_frst   <= 1'b0;
         r_txv    <= 1'b0;
         r_txb    <= 8'h00;
         r_sent   <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_wcnt   <= w_wcnt;
         r_bcnt   <= w_bcnt;
         r_tcnt   <= w_tcnt;
         r_rcnt   <= w_rcnt;
         r_settle <= w_settle;
         r_next   <= w_next;
         r_frst   <= w_frst;
         r_txv    <= w_txv;
         r_txb    <= w_txb;
         r_sent   <= w_sent;
         r_drop   <= w_drop;
      end
   end

endmodule

// File: tb/tb_pack_send.sv
`timescale 1ns/1ps
// tb_pack_send: drives pack_send from a simple packet-buffer model and a link
// sink, comparing the byte stream and pulses against a frame-level model.
module tb_pack_send;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TO   = 16;
   localparam int         MR   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] DataVal;
   logic        DataReady = 1'b0;
   logic        DataNext;
   logic        DataFrameReset;
   logic        Abort = 1'b0;
   logic [7:0]  TxByte;
   logic        TxValid;
   logic        TxReady = 1'b1;
   logic        LinkAck = 1'b0;
   logic        LinkNak = 1'b0;
   logic        FrameSent;
   logic        FrameDropped;
   logic        Busy;

   always #5 clk = ~clk;

   pack_send #(.SYNC_BYTE(SYNC), .ACK_TIMEOUT(TO), .MAX_RETRIES(MR)) dut (
      .clk(clk), .rst(rst), .DataVal(DataVal), .DataReady(DataReady),
      .DataNext(DataNext), .DataFrameReset(DataFrameReset), .Abort(Abort),
      .TxByte(TxByte), .TxValid(TxValid), .TxReady(TxReady),
      .LinkAck(LinkAck), .LinkNak(LinkNak), .FrameSent(FrameSent),
      .FrameDropped(FrameDropped), .Busy(Busy)
   );

   // Packet buffer model: 8 frames of 8 words, read pointer advanced by
   // DataNext rising edges and rewound to the frame start by DataFrameReset.
   logic [15:0] mem [64];
   logic [5:0]  ptr = 6'd0;
   logic        dn_prev_b = 1'b0;
   int          cyc = 0;
   assign DataVal = mem[ptr];

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      dn_prev_b <= DataNext;
      if (DataFrameReset) ptr <= ptr & 6'h38;
      else if (DataNext && !dn_prev_b) ptr <= ptr + 6'd1;
   end

   // Link-side monitor: records accepted bytes and counts pulses/edges.
   logic [7:0] rx_q [$];
   int         rx_cyc [$];
   int         dn_edges = 0, sent_n = 0, drop_n = 0, frst_n = 0;
   int         stab_err = 0, stalls = 0, drop_cyc = 0;
   logic       dn_prev_m = 1'b0, pend = 1'b0;
   logic [7:0] pend_byte = 8'h00;

   always @(negedge clk) begin
      if (TxValid && TxReady) begin
         rx_q.push_back(TxByte);
         rx_cyc.push_back(cyc);
      end
      if (TxValid && !TxReady) stalls <= stalls + 1;
      if (DataNext && !dn_prev_m) dn_edges <= dn_edges + 1;
      dn_prev_m <= DataNext;
      if (FrameSent) sent_n <= sent_n + 1;
      if (FrameDropped) begin
         drop_n   <= drop_n + 1;
         drop_cyc <= cyc;
      end
      if (DataFrameReset) frst_n <= frst_n + 1;
      if (!rst) begin
         pend <= 1'b0;
      end else begin
         if (pend && (!TxValid || TxByte != pend_byte)) stab_err <= stab_err + 1;
         pend      <= TxValid && !TxReady;
         pend_byte <= TxByte;
      end
   end

   int         n_checks = 0, n_err = 0;
   int         rx_base = 0, b_dn = 0, b_sent = 0, b_drop = 0, b_frst = 0, b_stab = 0, b_stall = 0;
   bit         rnd_rdy = 1'b0;
   logic       tx_hold = 1'b1;
   logic [7:0] exp_f [18];
   logic [5:0] fbase;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      TxReady = rnd_rdy ? 1'($urandom_range(0, 1)) : tx_hold;
   endtask

   task automatic snap();
      rx_base = rx_q.size();
      b_dn    = dn_edges;
      b_sent  = sent_n;
      b_drop  = drop_n;
      b_frst  = frst_n;
      b_stab  = stab_err;
      b_stall = stalls;
   endtask

   function automatic int cnt_sel(input int sel);
      case (sel)
         0:       return rx_q.size() - rx_base;
         1:       return dn_edges - b_dn;
         default: return drop_n - b_drop;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int n, input int budget, input string tag);
      int k = 0;
      int cur;
      cur = cnt_sel(sel);
      while (cur < n && k < budget) begin
         step();
         k++;
         cur = cnt_sel(sel);
      end
      check_eq({tag, "_reached"}, 32'(cur >= n), 32'd1);
   endtask

   // Reference frame: SYNC, each word low byte then high byte, XOR of data bytes.
   task automatic load_frame(input bit fixed);
      logic [7:0]  c;
      logic [15:0] w;
      c        = 8'h00;
      fbase    = ptr;
      exp_f[0] = SYNC;
      for (int i = 0; i < 8; i++) begin
         w = fixed ? 16'(i + 1) : 16'($urandom);
         mem[ptr + 6'(i)] = w;
         exp_f[1 + 2 * i] = w[7:0];
         exp_f[2 + 2 * i] = w[15:8];
         c = c ^ w[7:0] ^ w[15:8];
      end
      exp_f[17] = c;
   endtask

   task automatic fetch(input string tag);
      DataReady = 1'b1;
      wait_for(1, 8, 300, tag);
      DataReady = 1'b0;
   endtask

   task automatic cmp_frames(input string tag, input int nfr);
      int got;
      got = rx_q.size() - rx_base;
      check_eq({tag, "_nbytes"}, 32'(got), 32'(18 * nfr));
      for (int k = 0; k < 18 * nfr && k < got; k++)
         check_eq({tag, "_byte"}, 32'(rx_q[rx_base + k]), 32'(exp_f[k % 18]));
   endtask

   task automatic pulse_ack();
      LinkAck = 1'b1;
      step();
      LinkAck = 1'b0;
   endtask

   task automatic pulse_nak();
      LinkNak = 1'b1;
      step();
      LinkNak = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset applied before any clock edge.
      #2 rst = 1'b0;
      #1;
      check_eq("rst_datanext", 32'(DataNext), 32'd0);
      check_eq("rst_frst", 32'(DataFrameReset), 32'd0);
      check_eq("rst_txvalid", 32'(TxValid), 32'd0);
      check_eq("rst_txbyte", 32'(TxByte), 32'd0);
      check_eq("rst_sent", 32'(FrameSent), 32'd0);
      check_eq("rst_drop", 32'(FrameDropped), 32'd0);
      check_eq("rst_busy", 32'(Busy), 32'd0);
      repeat (3) step();
      rst = 1'b1;
      step();
      check_eq("post_rst_busy", 32'(Busy), 32'd0);

      // Fixed frame 0x0001..0x0008, full-rate sink, ACK right after last byte.
      snap();
      load_frame(1'b1);
      fetch("t1_fetch");
      wait_for(0, 18, 200, "t1_bytes");
      pulse_ack();
      repeat (4) step();
      cmp_frames("t1", 1);
      check_eq("t1_dn_edges", 32'(dn_edges - b_dn), 32'd8);
      check_eq("t1_sent", 32'(sent_n - b_sent), 32'd1);
      check_eq("t1_drop", 32'(drop_n - b_drop), 32'd0);
      check_eq("t1_busy", 32'(Busy), 32'd0);

      // Random frame, sink stalls at random.
      snap();
      load_frame(1'b0);
      rnd_rdy = 1'b1;
      fetch("t2_fetch");
      wait_for(0, 18, 800, "t2_bytes");
      rnd_rdy = 1'b0;
      pulse_ack();
      repeat (4) step();
      cmp_frames("t2", 1);
      check_eq("t2_stable", 32'(stab_err - b_stab), 32'd0);
      check_eq("t2_stalled", 32'((stalls - b_stall) > 0), 32'd1);
      check_eq("t2_sent", 32'(sent_n - b_sent), 32'd1);

      // NAK on first attempt, ACK on second.
      snap();
      load_frame(1'b0);
      fetch("t3_fetch");
      wait_for(0, 18, 200, "t3_bytes1");
      pulse_nak();
      wait_for(0, 36, 200, "t3_bytes2");
      pulse_ack();
      repeat (4) step();
      cmp_frames("t3", 2);
      check_eq("t3_dn_edges", 32'(dn_edges - b_dn), 32'd8);
      check_eq("t3_frst", 32'(frst_n - b_frst), 32'd0);
      check_eq("t3_sent", 32'(sent_n - b_sent), 32'd1);
      check_eq("t3_drop", 32'(drop_n - b_drop), 32'd0);

      // No ACK ever: 4 attempts, each followed by the timeout, then a drop.
      snap();
      load_frame(1'b0);
      fetch("t4_fetch");
      wait_for(2, 1, 800, "t4_drop_wait");
      repeat (3) step();
      cmp_frames("t4", 4);
      if (rx_q.size() - rx_base >= 72) begin
         for (int f = 1; f < 4; f++)
            check_eq("t4_gap", 32'(rx_cyc[rx_base + 18 * f] - rx_cyc[rx_base + 18 * f - 1]), 32'd17);
         check_eq("t4_drop_at", 32'(drop_cyc - rx_cyc[rx_base + 71]), 32'd17);
      end
      check_eq("t4_dn_edges", 32'(dn_edges - b_dn), 32'd8);
      check_eq("t4_drop", 32'(drop_n - b_drop), 32'd1);
      check_eq("t4_sent", 32'(sent_n - b_sent), 32'd0);
      check_eq("t4_busy", 32'(Busy), 32'd0);

      // Buffer stalls after the 3rd capture, then Abort rewinds the frame.
      snap();
      load_frame(1'b0);
      DataReady = 1'b1;
      wait_for(1, 2, 100, "t5_two_edges");
      DataReady = 1'b0;
      repeat (10) step();
      check_eq("t5_held_edges", 32'(dn_edges - b_dn), 32'd2);
      check_eq("t5_held_busy", 32'(Busy), 32'd1);
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      repeat (3) step();
      check_eq("t5_frst", 32'(frst_n - b_frst), 32'd1);
      check_eq("t5_datanext", 32'(DataNext), 32'd0);
      check_eq("t5_nbytes", 32'(rx_q.size() - rx_base), 32'd0);
      check_eq("t5_busy", 32'(Busy), 32'd0);
      check_eq("t5_rewind", 32'(ptr), 32'(fbase));
      snap();
      fetch("t5_refetch");
      wait_for(0, 18, 200, "t5_bytes");
      pulse_ack();
      repeat (4) step();
      cmp_frames("t5", 1);
      check_eq("t5_sent", 32'(sent_n - b_sent), 32'd1);

      // Asynchronous reset while the 6th byte is pending.
      snap();
      load_frame(1'b0);
      fetch("t6_fetch");
      wait_for(0, 5, 200, "t6_five");
      tx_hold = 1'b0;
      TxReady = 1'b0;
      step();
      step();
      #3;
      check_eq("t6_pend_valid", 32'(TxValid), 32'd1);
      check_eq("t6_pend_byte", 32'(TxByte), 32'(exp_f[5]));
      rst = 1'b0;
      #1;
      check_eq("t6_rst_txvalid", 32'(TxValid), 32'd0);
      check_eq("t6_rst_datanext", 32'(DataNext), 32'd0);
      check_eq("t6_rst_busy", 32'(Busy), 32'd0);
      step();
      rst     = 1'b1;
      tx_hold = 1'b1;
      TxReady = 1'b1;
      step();
      check_eq("t6_after_busy", 32'(Busy), 32'd0);
      snap();
      load_frame(1'b0);
      fetch("t6_refetch");
      wait_for(0, 18, 200, "t6_bytes");
      pulse_ack();
      repeat (4) step();
      cmp_frames("t6", 1);
      check_eq("t6_sent", 32'(sent_n - b_sent), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pack_send.md
Name: pack_send

Overview:
- Consumer end of the packet buffer's read interface.
- Pulls one 8-word (16-bit) frame out of the buffer using the DataNext/DataReady/DataFrameReset handshake and copies it into a local frame store.
- Sends the frame as a checked byte stream to the link layer, then retransmits from the local store on NAK or ACK timeout until the frame is acknowledged or dropped.

Parameters:
- SYNC_BYTE, 8'hA5, header byte that opens every transmitted frame.
- ACK_TIMEOUT, 1024, cycles to wait in WAIT_ACK before treating the attempt as failed; legal range 1..65535.
- MAX_RETRIES, 3, retransmissions allowed after the first attempt before the frame is dropped.

Ports:
- clk  in  1  System clock; the same clock as the buffer's read side.
- rst  in  1  Asynchronous, active-low reset.
- DataVal  in  16  Buffer word at the current read position.
- DataReady  in  1  Buffer may be advanced.
- DataNext  out  1  Rising edge advances the buffer read pointer.
- DataFrameReset  out  1  Rewinds the buffer to the start of the current frame.
- Abort  in  1  Abandon the frame currently being fetched or sent.
- TxByte  out  8  Outgoing byte.
- TxValid  out  1  TxByte is valid.
- TxReady  in  1  Sink accepts the byte this cycle.
- LinkAck  in  1  Frame acknowledged (one-cycle pulse).
- LinkNak  in  1  Frame rejected (one-cycle pulse).
- FrameSent  out  1  One-cycle pulse when a frame is acknowledged.
- FrameDropped  out  1  One-cycle pulse when a frame is abandoned.
- Busy  out  1  High in every state except IDLE.

Behaviour:
- Reset (rst=0), asynchronous and immediate:
  - DataNext, DataFrameReset, TxValid, FrameSent, FrameDropped and Busy are all 0; TxByte=0.
  - State=IDLE; word counter, byte counter, retry counter and timeout counter are all 0.
- State machine: IDLE, CAPTURE, NEXT_HI, SETTLE, ADV_WAIT, SEND, WAIT_ACK.
- IDLE: if DataReady=1, go to CAPTURE with wcnt=0.
- CAPTURE: store DataVal into word[wcnt], then go to ADV_WAIT.
- ADV_WAIT:
  - If DataReady=1, drive DataNext=1 and go to NEXT_HI.
  - Otherwise hold in ADV_WAIT indefinitely.
- NEXT_HI: drive DataNext=0 and go to SETTLE.
  - DataNext is therefore high for exactly one cycle per advance.
- SETTLE: lasts 2 cycles, so the next capture happens no earlier than 3 cycles after DataNext rose. At the end of SETTLE:
  - If wcnt=7, go to SEND with bcnt=0.
  - Otherwise increment wcnt and go to CAPTURE.
- Each frame produces exactly 8 rising edges on DataNext, the last one moving the buffer on to the next frame.
- SEND: 18 bytes in this order:
  - SYNC_BYTE.
  - For words 0..7: low byte, then high byte.
  - CHK, the XOR of the 16 data bytes. CHK is computed during CAPTURE, so it is ready before SEND starts.
- SEND handshake:
  - TxValid stays high and TxByte stays stable until the cycle in which TxReady=1.
  - The next byte is presented the following cycle; at full rate that is one byte per cycle.
  - After byte 17 is accepted, go to WAIT_ACK with tcnt=0.
- WAIT_ACK: tcnt increments every cycle; Busy stays high.
  - LinkAck=1 and LinkNak=0: pulse FrameSent, clear rcnt, go to IDLE.
  - LinkNak=1, or tcnt reaches ACK_TIMEOUT-1, while rcnt<MAX_RETRIES: increment rcnt and restart SEND at bcnt=0.
  - Retransmission always comes from the local store: no DataNext edges and no DataFrameReset.
  - The same failure with rcnt=MAX_RETRIES: pulse FrameDropped, clear rcnt, go to IDLE.
- Simultaneous LinkAck and LinkNak: NAK wins.
- LinkAck and LinkNak are ignored in every state other than WAIT_ACK.
- Abort during CAPTURE, ADV_WAIT, NEXT_HI or SETTLE:
  - Pulse DataFrameReset for one cycle and force DataNext=0.
  - Go to IDLE; no Tx bytes are emitted.
- Abort during SEND or WAIT_ACK:
  - Drop TxValid the next cycle and pulse FrameDropped.
  - No DataFrameReset, because the frame has already been consumed; go to IDLE.
- Abort in IDLE has no effect.
- Counter widths: wcnt 3 bits, bcnt 5 bits, tcnt 16 bits, rcnt wide enough for MAX_RETRIES. No wrap is ever reachable.

Test Plan:
- Buffer model holds words 0x0001..0x0008, TxReady=1, LinkAck one cycle after the last byte -> bytes A5 01 00 02 00 03 00 04 00 05 00 06 00 07 00 08 00 08; exactly 8 DataNext rising edges; exactly 1 FrameSent pulse.
- Same frame with TxReady randomly deasserted 50% of cycles -> identical 18-byte sequence; TxByte never changes while TxValid=1 and TxReady=0.
- LinkNak after the first attempt, LinkAck after the second -> 36 bytes made of two identical frames; still only 8 DataNext edges; exactly 1 FrameSent.
- No LinkAck ever, ACK_TIMEOUT=16, MAX_RETRIES=3 -> 4 identical frames (72 bytes), each followed by a 16-cycle wait; FrameDropped pulses once after the 4th timeout; Busy=0 afterwards.
- DataReady held low after the 3rd capture, then Abort -> one-cycle DataFrameReset pulse, DataNext=0, no Tx bytes; the next frame restarts cleanly with wcnt=0.
- rst driven low while the 6th byte is pending -> TxValid and DataNext go to 0 without waiting for a clock edge; after release, Busy=0 and the next frame starts with SYNC_BYTE.
